// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-queue bus bundle (redirect, imem request/response, decode handshake)
//   master: the fetch queue (drives imem request and decode outputs)
//   slave : the environment (execute redirect, instruction memory, decode stage)
interface fetch_queue_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
);
    logic                     redirect_i;
    logic [AWIDTH-1:0]        redirect_pc_i;
    logic                     imem_req_o;
    logic [AWIDTH-1:0]        imem_addr_o;
    logic [DWIDTH-1:0]        imem_data_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [AWIDTH-1:0]        out_pc_o;
    logic [DWIDTH-1:0]        out_insn_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_data_i, out_ready_i,
        output imem_req_o, imem_addr_o, out_valid_o, out_pc_o, out_insn_o, count_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_data_i, out_ready_i,
        input  imem_req_o, imem_addr_o, out_valid_o, out_pc_o, out_insn_o, count_o
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between imem and decode
//   clk, reset (async, active-high)
//   bus.redirect_i/redirect_pc_i : squash and restart fetch at a new PC
//   bus.imem_req_o/imem_addr_o   : one-word read request, data returns next cycle on imem_data_i
//   bus.out_valid_o/out_ready_i  : {out_pc_o, out_insn_o} handshake to decode
//   bus.count_o                  : FIFO occupancy
module fetch_queue #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 'h01000000,
    parameter int                DEPTH    = 4
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DWIDTH-1:0] NOP = 'h13;

    logic [AWIDTH-1:0] fetch_pc, inflight_pc;
    logic              inflight;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [AWIDTH-1:0] pc_q   [DEPTH];
    logic [DWIDTH-1:0] insn_q [DEPTH];
    logic              req, push, valid, pop;

    // Credit rule: counting the in-flight word guarantees a free slot for every response.
    always_comb begin
        req   = ~reset & ~bus.redirect_i & ((count + CW'(inflight)) < CW'(DEPTH));
        push  = inflight & ~bus.redirect_i;
        valid = (count != '0) & ~bus.redirect_i;
        pop   = valid & bus.out_ready_i;
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = fetch_pc;
    assign bus.out_valid_o = valid;
    assign bus.out_pc_o    = (count != '0) ? pc_q[rd_ptr] : '0;
    assign bus.out_insn_o  = (count != '0) ? insn_q[rd_ptr] : NOP;
    assign bus.count_o     = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= BASEADDR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (bus.redirect_i) begin
            fetch_pc <= {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= req;
            if (req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + AWIDTH'(4);
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only observed when count says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= inflight_pc;
            insn_q[wr_ptr] <= bus.imem_data_i;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue against a queue-level reference model
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h01000000;
    localparam logic [31:0] KEY   = 32'hA5A5A5A5;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] prev_addr = '0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] mq[$];
    logic [31:0] sb[$];
    logic        m_inf;
    logic [31:0] m_inf_pc, m_pc;

    fetch_queue_if #(.AWIDTH(32), .DWIDTH(32), .DEPTH(DEPTH)) bus();

    fetch_queue #(.AWIDTH(32), .DWIDTH(32), .BASEADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory returns addr ^ KEY for the address presented in the previous cycle.
    always @(posedge clk) prev_addr <= bus.imem_addr_o;
    assign bus.imem_data_i = prev_addr ^ KEY;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_inf    = 1'b0;
        m_inf_pc = '0;
        m_pc     = BASE;
    endtask

    task automatic do_reset(input int dly);
        #dly reset = 1'b1;
        #1;
        check("rst_req", 32'(bus.imem_req_o), 0);
        check("rst_addr", bus.imem_addr_o, BASE);
        check("rst_valid", 32'(bus.out_valid_o), 0);
        check("rst_pc", bus.out_pc_o, 0);
        check("rst_insn", bus.out_insn_o, NOP);
        check("rst_count", 32'(bus.count_o), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One cycle: drive inputs just after negedge, compare, advance the model across the next posedge.
    task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
        int   cnt;
        logic m_req, m_valid;
        bus.out_ready_i   = rdy;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        #1;
        cnt     = mq.size();
        m_req   = !rd && (cnt + int'(m_inf) < DEPTH);
        m_valid = (cnt != 0) && !rd;
        check("req", 32'(bus.imem_req_o), 32'(m_req));
        check("addr", bus.imem_addr_o, m_pc);
        check("valid", 32'(bus.out_valid_o), 32'(m_valid));
        check("count", 32'(bus.count_o), 32'(cnt));
        check("head_pc", bus.out_pc_o, cnt != 0 ? mq[0] : 32'h0);
        check("head_insn", bus.out_insn_o, cnt != 0 ? (mq[0] ^ KEY) : NOP);
        if (rd) begin
            mq.delete();
            sb.delete();
            m_inf = 1'b0;
            m_pc  = {rpc[31:2], 2'b00};
        end else begin
            if (m_valid && rdy) void'(mq.pop_front());
            if (m_inf) mq.push_back(m_inf_pc);
            m_inf = m_req;
            if (m_req) begin
                m_inf_pc = m_pc;
                sb.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every completed handshake must match the oldest outstanding request.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && bus.out_valid_o && bus.out_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual_pc=%h expected=none at %0t", bus.out_pc_o, $time);
                end else begin
                    exp = sb.pop_front();
                    check("sb_pc", bus.out_pc_o, exp);
                    check("sb_insn", bus.out_insn_o, exp ^ KEY);
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        bus.out_ready_i   = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        model_reset();
        @(negedge clk);
        do_reset(0);
        repeat (12) step(1'b1, 1'b0, '0);
        repeat (10) step(1'b0, 1'b0, '0);
        repeat (10) step(1'b1, 1'b0, '0);
        do_reset(0);
        repeat (4) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h01000102);
        repeat (8) step(1'b1, 1'b0, '0);
        do_reset(0);
        repeat (3) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'h01000040);
        repeat (6) step(1'b1, 1'b0, '0);
        repeat (5) step(1'b1, 1'b0, '0);
        do_reset(3);
        repeat (6) step(1'b1, 1'b0, '0);
        for (int i = 0; i < 500; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                              : (BASE + 32'($urandom_range(0, 255)));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), rpc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
